// File: rtl/dsp_simd_pkg.sv
// Shared types and constants for the SIMD-2x packed DSP datapath.
// unpack2 splits a packed two-lane accumulator into signed lane results.
package dsp_simd_pkg;

  localparam int unsigned P_W      = 48;
  localparam int unsigned LANE_W   = 20;
  localparam int unsigned MAX_TAPS = 4;
  localparam int unsigned ACC_W    = 2 * LANE_W;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef logic [ACC_W-1:0] acc_t;

  typedef struct packed {
    lane_t      hi;
    lane_t      lo;
    logic [2:0] taps;
  } simd2_res_t;

  // A negative low lane borrowed one from the upper field; adding its sign bit restores it.
  function automatic simd2_res_t unpack2(input acc_t acc);
    simd2_res_t res;
    res.lo   = lane_t'(acc[LANE_W-1:0]);
    res.hi   = lane_t'(acc[ACC_W-1:LANE_W]) + lane_t'({{(LANE_W-1){1'b0}}, acc[LANE_W-1]});
    res.taps = '0;
    return res;
  endfunction

endpackage

// File: rtl/dsp_simd2x_unpack_acc_if.sv
// Packed-product input stream and unpacked lane-result output stream.
interface dsp_simd2x_unpack_acc_if;
  import dsp_simd_pkg::*;

  logic           s_valid;
  logic           s_ready;
  logic [P_W-1:0] s_packed;
  logic           s_last;
  logic           m_valid;
  logic           m_ready;
  lane_t          m_hi;
  lane_t          m_lo;
  logic [2:0]     m_taps;
  logic           err_overrun;

  modport slave (
    input  s_valid, s_packed, s_last, m_ready,
    output s_ready, m_valid, m_hi, m_lo, m_taps, err_overrun
  );

  modport master (
    output s_valid, s_packed, s_last, m_ready,
    input  s_ready, m_valid, m_hi, m_lo, m_taps, err_overrun
  );

endinterface

// File: rtl/dsp_simd2x_unpack_acc_skid_buffer.sv
// Generic 2-entry valid/ready register slice; in_ready depends only on local state,
// so there is no combinational path from out_ready to in_ready.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic aresetn,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic push, pop;

  assign in_ready  = !skid_vld_q;
  assign push      = in_valid && in_ready;
  assign pop       = main_vld_q && out_ready;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || pop) begin
      // Older skid entry goes first to keep strict FIFO order.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/dsp_simd2x_unpack_acc.sv
// Accumulates packed SIMD-2x DSP products over a tap group, then unpacks the sum into
// two signed lanes and queues the pair through a 2-entry output slice.
module dsp_simd2x_unpack_acc
  import dsp_simd_pkg::*;
(
  input logic                   clk,
  input logic                   aresetn,
  dsp_simd2x_unpack_acc_if.slave bus
);

  localparam logic [2:0] TapsMax = 3'(MAX_TAPS);
  localparam logic [2:0] TapsSat = 3'd7;

  acc_t       acc_q, acc_d, acc_next;
  logic [2:0] tap_cnt_q, tap_cnt_d, tap_cnt_next;
  logic       first_q, first_d;
  logic       err_q, err_d;
  logic       accept, push, push_ready;
  simd2_res_t push_res, out_res;
  logic       unused_upper;

  assign unused_upper = ^bus.s_packed[P_W-1:ACC_W];
  assign accept       = bus.s_valid && push_ready;
  assign push         = accept && bus.s_last;

  always_comb begin
    acc_next     = (first_q ? '0 : acc_q) + bus.s_packed[ACC_W-1:0];
    tap_cnt_next = first_q ? 3'd1 : ((tap_cnt_q == TapsSat) ? TapsSat : tap_cnt_q + 3'd1);

    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    first_d   = first_q;
    err_d     = err_q;
    if (accept) begin
      acc_d     = acc_next;
      tap_cnt_d = tap_cnt_next;
      first_d   = bus.s_last;
      if (tap_cnt_next > TapsMax) begin
        err_d = 1'b1;
      end
    end

    push_res      = unpack2(acc_next);
    push_res.taps = tap_cnt_next;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q     <= '0;
      tap_cnt_q <= '0;
      first_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      tap_cnt_q <= tap_cnt_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  skid_buffer #(
    .T(simd2_res_t)
  ) u_out_slice (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_valid (push),
    .in_ready (push_ready),
    .in_data  (push_res),
    .out_valid(bus.m_valid),
    .out_ready(bus.m_ready),
    .out_data (out_res)
  );

  assign bus.s_ready     = push_ready;
  assign bus.m_hi        = out_res.hi;
  assign bus.m_lo        = out_res.lo;
  assign bus.m_taps      = out_res.taps;
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_dsp_simd2x_unpack_acc.sv
// Bench for dsp_simd2x_unpack_acc: lane sums are modelled directly as sum(a*c), sum(b*c).
module tb_dsp_simd2x_unpack_acc;
  import dsp_simd_pkg::*;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  dsp_simd2x_unpack_acc_if bus ();

  dsp_simd2x_unpack_acc dut (
    .clk    (clk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ga[16];
  int gb[16];
  int gc[16];

  function automatic logic [P_W-1:0] pack_beat(input int a, input int b, input int c,
                                               input bit junk);
    longint p;
    logic [P_W-1:0] v;
    p = ((longint'(a) << LANE_W) + longint'(b)) * longint'(c);
    v = p[P_W-1:0];
    if (junk) v[P_W-1:ACC_W] = 8'($urandom);
    return v;
  endfunction

  function automatic simd2_res_t model(input int n);
    longint hs = 0;
    longint ls = 0;
    simd2_res_t r;
    for (int i = 0; i < n; i++) begin
      hs += longint'(ga[i] * gc[i]);
      ls += longint'(gb[i] * gc[i]);
    end
    r.hi   = lane_t'(hs);
    r.lo   = lane_t'(ls);
    r.taps = (n > 7) ? 3'd7 : 3'(n);
    return r;
  endfunction

  task automatic rand_ops(input int n, input int cmin, input int cmax);
    for (int i = 0; i < n; i++) begin
      ga[i] = int'($urandom_range(255, 0));
      gb[i] = int'($urandom_range(255, 0));
      gc[i] = int'($urandom_range(cmax - cmin, 0)) + cmin;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [P_W-1:0] p, input logic last);
    int guard = 0;
    while (!bus.s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept_timeout: s_ready=%0b required 1", bus.s_ready);
      return;
    end
    bus.s_valid  = 1'b1;
    bus.s_packed = p;
    bus.s_last   = last;
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_group(input int n, input bit junk, output simd2_res_t exp);
    for (int i = 0; i < n; i++) begin
      send_beat(pack_beat(ga[i], gb[i], gc[i], junk), (i == n - 1));
    end
    exp = model(n);
  endtask

  task automatic test_reset();
    simd2_res_t got;
    aresetn      = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_packed = '0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    got = {bus.m_hi, bus.m_lo, bus.m_taps};
    n_cmp++;
    if (bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_s_ready: got %0b required 1", bus.s_ready);
    end
    n_cmp++;
    if (bus.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_m_valid: got %0b required 0", bus.m_valid);
    end
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got hi=%0d lo=%0d taps=%0d required all 0",
               got.hi, got.lo, got.taps);
    end
    n_cmp++;
    if (bus.err_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %0b required 0", bus.err_overrun);
    end
  endtask

  // Directed groups with results fixed by hand: {a,b,c} triples, hi, lo, taps.
  task automatic test_directed();
    simd2_res_t exp, got, req[3];
    int n[3];
    n[0] = 1; n[1] = 4; n[2] = 4;
    req[0] = {lane_t'(-600), lane_t'(-300), 3'd1};
    req[1] = {lane_t'(-261120), lane_t'(-261120), 3'd4};
    req[2] = {lane_t'(48), lane_t'(-262), 3'd4};
    bus.m_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        ga[0] = 200; gb[0] = 100; gc[0] = -3;
      end else if (t == 1) begin
        for (int i = 0; i < 4; i++) begin
          ga[i] = 255; gb[i] = 255; gc[i] = -256;
        end
      end else begin
        ga[0] = 10; gb[0] = 0;   gc[0] = 5;
        ga[1] = 0;  gb[1] = 7;   gc[1] = -9;
        ga[2] = 3;  gb[2] = 200; gc[2] = -1;
        ga[3] = 1;  gb[3] = 1;   gc[3] = 1;
      end
      send_group(n[t], 1'b0, exp);
      got = {bus.m_hi, bus.m_lo, bus.m_taps};
      n_cmp++;
      if (bus.m_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL directed%0d_latency: m_valid=%0b required 1", t, bus.m_valid);
      end
      n_cmp++;
      if (got !== req[t]) begin
        n_bad++;
        $display("FAIL directed%0d_result: got hi=%0d lo=%0d taps=%0d required hi=%0d lo=%0d taps=%0d",
                 t, got.hi, got.lo, got.taps, req[t].hi, req[t].lo, req[t].taps);
      end
      n_cmp++;
      if (bus.err_overrun !== 1'b0) begin
        n_bad++;
        $display("FAIL directed%0d_err: got %0b required 0", t, bus.err_overrun);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.m_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL directed%0d_pop: m_valid=%0b required 0", t, bus.m_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [P_W-1:0] pk[3];
    simd2_res_t ex[3];
    simd2_res_t got;
    simd2_res_t gotq[$];
    bit pend = 1'b1;
    bit acc_now = 1'b0;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_ops(1, -256, 255);
      pk[k] = pack_beat(ga[0], gb[0], gc[0], 1'b1);
      ex[k] = model(1);
    end
    send_beat(pk[0], 1'b1);
    send_beat(pk[1], 1'b1);
    n_cmp++;
    if (bus.s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_s_ready_drop: got %0b required 0", bus.s_ready);
    end
    bus.s_valid  = 1'b1;
    bus.s_packed = pk[2];
    bus.s_last   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      got = {bus.m_hi, bus.m_lo, bus.m_taps};
      n_cmp++;
      if (bus.m_valid !== 1'b1 || got !== ex[0]) begin
        n_bad++;
        $display("FAIL b2b_hold: valid=%0b hi=%0d lo=%0d required valid=1 hi=%0d lo=%0d",
                 bus.m_valid, got.hi, got.lo, ex[0].hi, ex[0].lo);
      end
      n_cmp++;
      if (bus.s_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_stall_s_ready: got %0b required 0", bus.s_ready);
      end
    end
    bus.m_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.m_valid) gotq.push_back({bus.m_hi, bus.m_lo, bus.m_taps});
      if (pend && bus.s_ready) acc_now = 1'b1;
      @(negedge clk);
      if (acc_now) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        pend        = 1'b0;
        acc_now     = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    n_cmp++;
    if (pend !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_third_accept: pending=%0b required 0", pend);
    end
    n_cmp++;
    if (gotq.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results required 3", gotq.size());
    end
    for (int k = 0; k < 3; k++) begin
      got = (k < gotq.size()) ? gotq[k] : '0;
      n_cmp++;
      if (got !== ex[k]) begin
        n_bad++;
        $display("FAIL b2b_order%0d: got hi=%0d lo=%0d taps=%0d required hi=%0d lo=%0d taps=%0d",
                 k, got.hi, got.lo, got.taps, ex[k].hi, ex[k].lo, ex[k].taps);
      end
    end
  endtask

  task automatic test_overrun();
    simd2_res_t exp, got;
    int n[3];
    int cl[3];
    n[0] = 5; n[1] = 9; n[2] = 3;
    cl[0] = 256; cl[1] = 64; cl[2] = 256;
    bus.m_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      rand_ops(n[t], -cl[t], cl[t] - 1);
      send_group(n[t], 1'b1, exp);
      got = {bus.m_hi, bus.m_lo, bus.m_taps};
      n_cmp++;
      if (bus.m_valid !== 1'b1 || got !== exp) begin
        n_bad++;
        $display("FAIL overrun%0d_result: valid=%0b hi=%0d lo=%0d taps=%0d required hi=%0d lo=%0d taps=%0d",
                 t, bus.m_valid, got.hi, got.lo, got.taps, exp.hi, exp.lo, exp.taps);
      end
      n_cmp++;
      if (bus.err_overrun !== 1'b1) begin
        n_bad++;
        $display("FAIL overrun%0d_err: got %0b required 1", t, bus.err_overrun);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_group();
    simd2_res_t exp, got;
    bus.m_ready = 1'b0;
    rand_ops(1, -256, 255);
    send_group(1, 1'b0, exp);
    rand_ops(2, -256, 255);
    send_beat(pack_beat(ga[0], gb[0], gc[0], 1'b0), 1'b0);
    send_beat(pack_beat(ga[1], gb[1], gc[1], 1'b0), 1'b0);
    aresetn = 1'b0;
    #1;
    got = {bus.m_hi, bus.m_lo, bus.m_taps};
    n_cmp++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || got !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: valid=%0b s_ready=%0b hi=%0d lo=%0d taps=%0d required 0 1 0 0 0",
               bus.m_valid, bus.s_ready, got.hi, got.lo, got.taps);
    end
    n_cmp++;
    if (bus.err_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_err: got %0b required 0", bus.err_overrun);
    end
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b1;
    rand_ops(1, -256, 255);
    send_group(1, 1'b1, exp);
    got = {bus.m_hi, bus.m_lo, bus.m_taps};
    n_cmp++;
    if (bus.m_valid !== 1'b1 || got !== exp) begin
      n_bad++;
      $display("FAIL midreset_fresh: valid=%0b hi=%0d lo=%0d taps=%0d required hi=%0d lo=%0d taps=%0d",
               bus.m_valid, got.hi, got.lo, got.taps, exp.hi, exp.lo, exp.taps);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_stale: m_valid=%0b required 0", bus.m_valid);
    end
  endtask

  task automatic test_random_groups();
    simd2_res_t exp, got;
    int n;
    bus.m_ready = 1'b1;
    for (int g = 0; g < 20; g++) begin
      n = int'($urandom_range(4, 1));
      rand_ops(n, -256, 255);
      send_group(n, 1'b1, exp);
      got = {bus.m_hi, bus.m_lo, bus.m_taps};
      n_cmp++;
      if (bus.m_valid !== 1'b1 || got !== exp) begin
        n_bad++;
        $display("FAIL random%0d: valid=%0b hi=%0d lo=%0d taps=%0d required hi=%0d lo=%0d taps=%0d",
                 g, bus.m_valid, got.hi, got.lo, got.taps, exp.hi, exp.lo, exp.taps);
      end
    end
    n_cmp++;
    if (bus.err_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL random_err: got %0b required 0", bus.err_overrun);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_groups();
    test_overrun();
    test_reset_mid_group();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
